// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction memory request/response channel.
// master = fetch unit, slave = instruction memory.
// With FETCH_ERR_EN defined the response also carries mem_rsp_err.
interface instr_fetch_unit_if #(
    parameter int unsigned INSTR_ADDR_WIDTH = 32,
    parameter int unsigned INSTR_WIDTH      = 32
);
    logic                        mem_req_valid;
    logic                        mem_req_ready;
    logic [INSTR_ADDR_WIDTH-1:0] mem_req_addr;
    logic                        mem_rsp_valid;
    logic [INSTR_WIDTH-1:0]      mem_rsp_data;
`ifdef FETCH_ERR_EN
    logic                        mem_rsp_err;
`endif

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid,
`ifdef FETCH_ERR_EN
        input  mem_rsp_err,
`endif
        input  mem_rsp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid,
`ifdef FETCH_ERR_EN
        output mem_rsp_err,
`endif
        output mem_rsp_data
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: takes one address at a time from the PC, issues it to
// instruction memory (one outstanding request), buffers {addr, instr} in a
// small FIFO and presents entries to decode. flush discards buffered and
// in-flight instructions.
// Optional macro FETCH_ERR_EN: per-entry response error bit (instr_err_out).
module instr_fetch_unit #(
    parameter int unsigned INSTR_ADDR_WIDTH = 32,
    parameter int unsigned INSTR_WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic                          clk,
    input  logic                          async_rst_n,
    input  logic                          clk_en,
    input  logic [INSTR_ADDR_WIDTH-1:0]   pc_addr_in,
    input  logic                          pc_valid_in,
    output logic                          stall_out,
    input  logic                          flush,
    instr_fetch_unit_if.master            mem,
    output logic                          instr_valid_out,
    input  logic                          instr_ready_in,
    output logic [INSTR_WIDTH-1:0]        instr_out,
    output logic [INSTR_ADDR_WIDTH-1:0]   instr_addr_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef FETCH_ERR_EN
    ,
    output logic                          instr_err_out
`endif
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                      state;
    logic                        discard;
    logic                        req_valid_q;
    logic [INSTR_ADDR_WIDTH-1:0] req_addr_q;

    logic [INSTR_ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
    logic [INSTR_WIDTH-1:0]      data_mem [FIFO_DEPTH];
`ifdef FETCH_ERR_EN
    logic                        err_mem  [FIFO_DEPTH];
`endif

    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_after_pop;
    logic             pop;
    logic             push;
    logic             space;
    logic             stall;
    logic             accept;

    // Occupancy, handshakes and the PC stall; space counts a same-cycle pop
    always_comb begin
        wr_idx          = wr_ptr[PTR_W-1:0];
        rd_idx          = rd_ptr[PTR_W-1:0];
        count           = wr_ptr - rd_ptr;
        pop             = clk_en && (count != '0) && instr_ready_in;
        count_after_pop = count - CNT_W'(pop);
        space           = count_after_pop < CNT_W'(FIFO_DEPTH);
        stall           = !((state == IDLE) && space) || flush;
        accept          = clk_en && (state == IDLE) && pc_valid_in && !stall;
        push            = clk_en && (state == WAIT) && mem.mem_rsp_valid
                          && !discard && !flush;
    end

    assign stall_out         = stall;
    assign fifo_count        = count;
    assign instr_valid_out   = (count != '0);
    assign instr_out         = data_mem[rd_idx];
    assign instr_addr_out    = addr_mem[rd_idx];
    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_req_addr  = req_addr_q;
`ifdef FETCH_ERR_EN
    assign instr_err_out     = (count != '0) && err_mem[rd_idx];
`endif

    // Request FSM: IDLE -> REQ on accept, REQ -> WAIT on ready, WAIT -> IDLE on response
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state       <= IDLE;
            discard     <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_addr_q  <= pc_addr_in;
                        req_valid_q <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    // valid is never retracted; a flush only marks the reply for dropping
                    if (flush) begin
                        discard <= 1'b1;
                    end
                    if (mem.mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    // a response completes the transaction, so discard never outlives it
                    if (mem.mem_rsp_valid) begin
                        discard <= 1'b0;
                        state   <= IDLE;
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Instruction buffer: flush empties it and overrides a same-cycle push/pop
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                addr_mem[PTR_W'(i)] <= '0;
                data_mem[PTR_W'(i)] <= '0;
`ifdef FETCH_ERR_EN
                err_mem[PTR_W'(i)]  <= 1'b0;
`endif
            end
        end else if (clk_en) begin
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (push) begin
                    addr_mem[wr_idx] <= req_addr_q;
                    data_mem[wr_idx] <= mem.mem_rsp_data;
`ifdef FETCH_ERR_EN
                    err_mem[wr_idx]  <= mem.mem_rsp_err;
`endif
                    wr_ptr <= wr_ptr + CNT_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table, hand-written corner-case
// sequences and a randomized run against a transaction-level model.
module tb_instr_fetch_unit;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          async_rst_n;
    logic          clk_en;
    logic [AW-1:0] pc_addr_in;
    logic          pc_valid_in;
    logic          stall_out;
    logic          flush;
    logic          instr_valid_out;
    logic          instr_ready_in;
    logic [DW-1:0] instr_out;
    logic [AW-1:0] instr_addr_out;
    logic [2:0]    fifo_count;
`ifdef FETCH_ERR_EN
    logic          instr_err_out;
`endif

    instr_fetch_unit_if #(.INSTR_ADDR_WIDTH(AW), .INSTR_WIDTH(DW)) mem_bus ();

    instr_fetch_unit #(
        .INSTR_ADDR_WIDTH(AW),
        .INSTR_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .async_rst_n(async_rst_n),
        .clk_en(clk_en),
        .pc_addr_in(pc_addr_in),
        .pc_valid_in(pc_valid_in),
        .stall_out(stall_out),
        .flush(flush),
        .mem(mem_bus),
        .instr_valid_out(instr_valid_out),
        .instr_ready_in(instr_ready_in),
        .instr_out(instr_out),
        .instr_addr_out(instr_addr_out),
        .fifo_count(fifo_count)
`ifdef FETCH_ERR_EN
        ,
        .instr_err_out(instr_err_out)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_F00D;
    endfunction

    task automatic idle_inputs();
        clk_en                = 1'b1;
        pc_valid_in           = 1'b0;
        pc_addr_in            = '0;
        flush                 = 1'b0;
        instr_ready_in        = 1'b0;
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rsp_data  = '0;
`ifdef FETCH_ERR_EN
        mem_bus.mem_rsp_err   = 1'b0;
`endif
    endtask

    // zero-wait fetch of one address; starts and ends in IDLE
    task automatic fetch_zw(input logic [31:0] a, input logic [31:0] d);
        pc_valid_in           = 1'b1;
        pc_addr_in            = a;
        mem_bus.mem_req_ready = 1'b1;
        tick();
        pc_valid_in = 1'b0;
        tick();
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_data  = d;
        tick();
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_req_ready = 1'b0;
    endtask

    typedef struct {
        bit          pv;
        logic [31:0] pa;
        bit          mrdy;
        bit          rspv;
        logic [31:0] rspd;
        bit          ir;
        bit          fl;
        bit          e_stall;
        bit          e_rv;
        logic [31:0] e_raddr;
        bit          e_iv;
        logic [31:0] e_iaddr;
        logic [31:0] e_instr;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[14];

    // transaction-level reference model state
    logic [31:0] mq_addr[$];
    logic [31:0] mq_data[$];
    bit          m_req_p;
    bit          m_rsp_p;
    bit          m_drop;
    logic [31:0] m_req_addr;
    logic [31:0] m_rsp_addr;
    logic [31:0] m_last_addr;
    int          m_delay;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //              pv    pa        mrdy  rspv  rspd           ir    fl   | stall rv    raddr    iv    iaddr    instr          cnt
        vecs[0]  = '{1'b1, 32'h0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,         3'd0};
        vecs[1]  = '{1'b1, 32'h4, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0,         3'd0};
        vecs[2]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,         3'd0};
        vecs[3]  = '{1'b1, 32'h4, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'hA000_0000, 3'd1};
        vecs[4]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0, 32'hA000_0000, 3'd1};
        vecs[5]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0004, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4, 1'b1, 32'h0, 32'hA000_0000, 3'd1};
        vecs[6]  = '{1'b1, 32'h8, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h4, 1'b1, 32'h0, 32'hA000_0000, 3'd2};
        vecs[7]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h8, 1'b1, 32'h0, 32'hA000_0000, 3'd2};
        vecs[8]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0008, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8, 1'b1, 32'h0, 32'hA000_0000, 3'd2};
        vecs[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 1'b1, 32'h0, 32'hA000_0000, 3'd3};
        vecs[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 1'b1, 32'h4, 32'hA000_0004, 3'd2};
        vecs[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 1'b1, 32'h8, 32'hA000_0008, 3'd1};
        vecs[12] = '{1'b1, 32'hC, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h8, 1'b0, 32'h0, 32'h0,         3'd0};
        vecs[13] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 1'b0, 32'h0, 32'h0,         3'd0};

        // reset state
        async_rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        #1;
        check("rst stall", 64'(stall_out), 64'h0);
        check("rst req_valid", 64'(mem_bus.mem_req_valid), 64'h0);
        check("rst req_addr", 64'(mem_bus.mem_req_addr), 64'h0);
        check("rst instr_valid", 64'(instr_valid_out), 64'h0);
        check("rst instr", 64'(instr_out), 64'h0);
        check("rst instr_addr", 64'(instr_addr_out), 64'h0);
        check("rst count", 64'(fifo_count), 64'h0);
        async_rst_n = 1'b1;
        tick();

        // zero-wait fetch of 0x0/0x4/0x8, drain, flush in IDLE
        for (int i = 0; i < 14; i++) begin
            pc_valid_in           = vecs[i].pv;
            pc_addr_in            = vecs[i].pa;
            mem_bus.mem_req_ready = vecs[i].mrdy;
            mem_bus.mem_rsp_valid = vecs[i].rspv;
            mem_bus.mem_rsp_data  = vecs[i].rspd;
            instr_ready_in        = vecs[i].ir;
            flush                 = vecs[i].fl;
            #1;
            check($sformatf("vec%0d stall", i), 64'(stall_out), 64'(vecs[i].e_stall));
            check($sformatf("vec%0d req_valid", i), 64'(mem_bus.mem_req_valid), 64'(vecs[i].e_rv));
            check($sformatf("vec%0d req_addr", i), 64'(mem_bus.mem_req_addr), 64'(vecs[i].e_raddr));
            check($sformatf("vec%0d instr_valid", i), 64'(instr_valid_out), 64'(vecs[i].e_iv));
            check($sformatf("vec%0d count", i), 64'(fifo_count), 64'(vecs[i].e_cnt));
            if (vecs[i].e_iv) begin
                check($sformatf("vec%0d instr_addr", i), 64'(instr_addr_out), 64'(vecs[i].e_iaddr));
                check($sformatf("vec%0d instr", i), 64'(instr_out), 64'(vecs[i].e_instr));
            end
            tick();
        end
        idle_inputs();

        // backpressure until full, then one pop lets the next address in
        for (int k = 0; k < 4; k++) begin
            fetch_zw(32'h10 + 32'(k) * 32'h4, 32'hB000_0000 + 32'(k));
        end
        #1;
        check("full count", 64'(fifo_count), 64'h4);
        check("full stall", 64'(stall_out), 64'h1);
        pc_valid_in = 1'b1;
        pc_addr_in  = 32'h50;
        #1;
        check("full stall pv", 64'(stall_out), 64'h1);
        tick();
        #1;
        check("full no req", 64'(mem_bus.mem_req_valid), 64'h0);
        check("full count hold", 64'(fifo_count), 64'h4);
        instr_ready_in = 1'b1;
        #1;
        check("full pop stall", 64'(stall_out), 64'h0);
        tick();
        pc_valid_in    = 1'b0;
        instr_ready_in = 1'b0;
        #1;
        check("full req_valid", 64'(mem_bus.mem_req_valid), 64'h1);
        check("full req_addr", 64'(mem_bus.mem_req_addr), 64'h50);
        check("full count3", 64'(fifo_count), 64'h3);
        mem_bus.mem_req_ready = 1'b1;
        tick();
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_data  = 32'hB000_0050;
        tick();
        mem_bus.mem_rsp_valid = 1'b0;
        instr_ready_in        = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("drain%0d addr", k), 64'(instr_addr_out),
                  (k == 3) ? 64'h50 : 64'h14 + 64'(k) * 64'h4);
            tick();
        end
        instr_ready_in = 1'b0;
        #1;
        check("drain empty", 64'(fifo_count), 64'h0);

        // request held stable while memory is not ready
        pc_valid_in = 1'b1;
        pc_addr_in  = 32'h100;
        tick();
        pc_valid_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("hold%0d valid", k), 64'(mem_bus.mem_req_valid), 64'h1);
            check($sformatf("hold%0d addr", k), 64'(mem_bus.mem_req_addr), 64'h100);
            tick();
        end
        mem_bus.mem_req_ready = 1'b1;
        #1;
        check("hold ready valid", 64'(mem_bus.mem_req_valid), 64'h1);
        tick();
        mem_bus.mem_req_ready = 1'b0;
        #1;
        check("hold wait valid", 64'(mem_bus.mem_req_valid), 64'h0);
        check("hold wait stall", 64'(stall_out), 64'h1);
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_data  = 32'hC000_0100;
        tick();
        mem_bus.mem_rsp_valid = 1'b0;
        #1;
        check("hold count", 64'(fifo_count), 64'h1);
        check("hold instr_addr", 64'(instr_addr_out), 64'h100);
        check("hold instr", 64'(instr_out), 64'hC000_0100);
        instr_ready_in = 1'b1;
        tick();
        instr_ready_in = 1'b0;

        // flush during WAIT drops buffer and late response
        fetch_zw(32'h20, 32'hD000_0020);
        fetch_zw(32'h30, 32'hD000_0030);
        pc_valid_in           = 1'b1;
        pc_addr_in            = 32'h40;
        mem_bus.mem_req_ready = 1'b1;
        tick();
        pc_valid_in = 1'b0;
        tick();
        mem_bus.mem_req_ready = 1'b0;
        #1;
        check("flw count2", 64'(fifo_count), 64'h2);
        flush = 1'b1;
        #1;
        check("flw stall", 64'(stall_out), 64'h1);
        tick();
        flush = 1'b0;
        #1;
        check("flw emptied", 64'(fifo_count), 64'h0);
        tick();
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_data  = 32'hD000_0040;
        tick();
        mem_bus.mem_rsp_valid = 1'b0;
        #1;
        check("flw dropped", 64'(fifo_count), 64'h0);
        check("flw ivalid", 64'(instr_valid_out), 64'h0);
        check("flw stall idle", 64'(stall_out), 64'h0);
        tick();
        #1;
        check("flw ivalid later", 64'(instr_valid_out), 64'h0);
        fetch_zw(32'h200, 32'hD000_0200);
        #1;
        check("flw next count", 64'(fifo_count), 64'h1);
        check("flw next addr", 64'(instr_addr_out), 64'h200);
        check("flw next instr", 64'(instr_out), 64'hD000_0200);
        instr_ready_in = 1'b1;
        tick();
        instr_ready_in = 1'b0;

        // asynchronous reset in WAIT
        fetch_zw(32'h60, 32'hE000_0060);
        pc_valid_in           = 1'b1;
        pc_addr_in            = 32'h300;
        mem_bus.mem_req_ready = 1'b1;
        tick();
        pc_valid_in = 1'b0;
        tick();
        mem_bus.mem_req_ready = 1'b0;
        #1;
        async_rst_n = 1'b0;
        #1;
        check("arst stall", 64'(stall_out), 64'h0);
        check("arst req_valid", 64'(mem_bus.mem_req_valid), 64'h0);
        check("arst req_addr", 64'(mem_bus.mem_req_addr), 64'h0);
        check("arst ivalid", 64'(instr_valid_out), 64'h0);
        check("arst instr", 64'(instr_out), 64'h0);
        check("arst iaddr", 64'(instr_addr_out), 64'h0);
        check("arst count", 64'(fifo_count), 64'h0);
        tick();
        async_rst_n = 1'b1;

        // clk_en low freezes a pending request and the buffer
        fetch_zw(32'h3F0, 32'hE000_03F0);
        pc_valid_in = 1'b1;
        pc_addr_in  = 32'h400;
        tick();
        pc_valid_in           = 1'b0;
        clk_en                = 1'b0;
        mem_bus.mem_req_ready = 1'b1;
        instr_ready_in        = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("cken%0d valid", k), 64'(mem_bus.mem_req_valid), 64'h1);
            check($sformatf("cken%0d addr", k), 64'(mem_bus.mem_req_addr), 64'h400);
            check($sformatf("cken%0d stall", k), 64'(stall_out), 64'h1);
            check($sformatf("cken%0d count", k), 64'(fifo_count), 64'h1);
            tick();
        end
        clk_en                = 1'b1;
        mem_bus.mem_req_ready = 1'b0;
        instr_ready_in        = 1'b0;
        #1;
        check("cken resume valid", 64'(mem_bus.mem_req_valid), 64'h1);
        check("cken resume head", 64'(instr_addr_out), 64'h3F0);
        mem_bus.mem_req_ready = 1'b1;
        tick();
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_data  = 32'hE000_0400;
        tick();
        mem_bus.mem_rsp_valid = 1'b0;
        #1;
        check("cken count2", 64'(fifo_count), 64'h2);
        instr_ready_in = 1'b1;
        tick();
        #1;
        check("cken second", 64'(instr_addr_out), 64'h400);
        tick();
        instr_ready_in = 1'b0;

`ifdef FETCH_ERR_EN
        // per-entry error bit
        begin
            logic [2:0] exp_err;
            exp_err = 3'b010;
            for (int k = 0; k < 3; k++) begin
                mem_bus.mem_rsp_err = exp_err[k];
                fetch_zw(32'h4 + 32'(k) * 32'h4, 32'hF000_0000 + 32'(k));
            end
            mem_bus.mem_rsp_err = 1'b0;
            instr_ready_in = 1'b1;
            for (int k = 0; k < 3; k++) begin
                #1;
                check($sformatf("err%0d", k), 64'(instr_err_out), 64'(exp_err[k]));
                tick();
            end
            instr_ready_in = 1'b0;
            #1;
            check("err empty", 64'(instr_err_out), 64'h0);
        end
`endif

        // randomized run against the transaction-level model
        async_rst_n = 1'b0;
        idle_inputs();
        tick();
        async_rst_n = 1'b1;
        m_req_p     = 1'b0;
        m_rsp_p     = 1'b0;
        m_drop      = 1'b0;
        m_req_addr  = '0;
        m_rsp_addr  = '0;
        m_last_addr = '0;
        m_delay     = 0;
        mq_addr.delete();
        mq_data.delete();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            bit          en, pv, fl, mrdy, ir, rspv, pop_now, exp_stall, accept;
            logic [31:0] pa;
            en   = ($urandom_range(7) != 0);
            pv   = ($urandom_range(3) != 0);
            pa   = $urandom;
            fl   = ($urandom_range(19) == 0);
            mrdy = ($urandom_range(1) == 1);
            ir   = (((cyc / 300) % 2) == 0) ? ($urandom_range(4) == 0) : ($urandom_range(3) != 0);
            rspv = m_rsp_p && (m_delay == 0);

            clk_en                = en;
            pc_valid_in           = pv;
            pc_addr_in            = pa;
            flush                 = fl;
            mem_bus.mem_req_ready = mrdy;
            mem_bus.mem_rsp_valid = rspv;
            mem_bus.mem_rsp_data  = rspv ? mem_data(m_rsp_addr) : $urandom;
            instr_ready_in        = ir;

            pop_now   = en && ir && (mq_addr.size() != 0);
            exp_stall = m_req_p || m_rsp_p || fl
                        || ((mq_addr.size() - (pop_now ? 1 : 0)) >= DEPTH);
            #1;
            check($sformatf("rnd%0d count", cyc), 64'(fifo_count), 64'(mq_addr.size()));
            check($sformatf("rnd%0d ivalid", cyc), 64'(instr_valid_out), 64'(mq_addr.size() != 0));
            if (mq_addr.size() != 0) begin
                check($sformatf("rnd%0d iaddr", cyc), 64'(instr_addr_out), 64'(mq_addr[0]));
                check($sformatf("rnd%0d instr", cyc), 64'(instr_out), 64'(mq_data[0]));
            end
            check($sformatf("rnd%0d req_valid", cyc), 64'(mem_bus.mem_req_valid), 64'(m_req_p));
            check($sformatf("rnd%0d req_addr", cyc), 64'(mem_bus.mem_req_addr), 64'(m_last_addr));
            check($sformatf("rnd%0d stall", cyc), 64'(stall_out), 64'(exp_stall));

            if (en) begin
                accept = !m_req_p && !m_rsp_p && pv && !exp_stall;
                if (pop_now && !fl) begin
                    void'(mq_addr.pop_front());
                    void'(mq_data.pop_front());
                end
                if (rspv) begin
                    if (!m_drop && !fl) begin
                        mq_addr.push_back(m_rsp_addr);
                        mq_data.push_back(mem_data(m_rsp_addr));
                    end
                    m_drop  = 1'b0;
                    m_rsp_p = 1'b0;
                end else if (fl && (m_req_p || m_rsp_p)) begin
                    m_drop = 1'b1;
                end
                if (fl) begin
                    mq_addr.delete();
                    mq_data.delete();
                end
                if (m_rsp_p && (m_delay > 0)) begin
                    m_delay--;
                end
                if (m_req_p && mrdy) begin
                    m_req_p    = 1'b0;
                    m_rsp_p    = 1'b1;
                    m_rsp_addr = m_req_addr;
                    m_delay    = int'($urandom_range(2));
                end
                if (accept) begin
                    m_req_p     = 1'b1;
                    m_req_addr  = pa;
                    m_last_addr = pa;
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
